// File: rtl/hex_digit_counter.sv
// Multi-digit up/down counter with rate divider, parallel load and pause; feeds 7-segment decoders.
// Define HEX_DIGIT_COUNTER_BCD_EN for BCD digits (0..9, loads clamped to 9); hex digits otherwise.
module hex_digit_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int PERIOD_1   = 50000000,
  parameter int PERIOD_2   = 25000000,
  parameter int PERIOD_3   = 12500000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              speed,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    wrap
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int MAX12 = (PERIOD_1 > PERIOD_2) ? PERIOD_1 : PERIOD_2;
  localparam int MAXP  = (MAX12 > PERIOD_3) ? MAX12 : PERIOD_3;
  localparam int DW    = (MAXP > 1) ? $clog2(MAXP) : 1;

`ifdef HEX_DIGIT_COUNTER_BCD_EN
  localparam logic [3:0] DMAX = 4'd9;
`else
  localparam logic [3:0] DMAX = 4'hF;
`endif

  logic [DW-1:0] div_q;
  logic [1:0]    speed_q;
  logic [W-1:0]  digits_q;
  logic          tick_q;
  logic          wrap_q;

  logic [W-1:0]  next_digits;
  logic [W-1:0]  load_digits;
  logic          roll;
  logic          carry;
  logic [3:0]    cur_d;
  logic [3:0]    nxt_d;
  logic          speed_chg;

  function automatic logic [DW-1:0] reload_of(input logic [1:0] s);
    logic [DW-1:0] r;
    case (s)
      2'b01:   r = DW'(PERIOD_1 - 1);
      2'b10:   r = DW'(PERIOD_2 - 1);
      2'b11:   r = DW'(PERIOD_3 - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign speed_chg = (speed != speed_q);

  // Ripple step: a digit moves only while every lower digit sits at its rollover value.
  always_comb begin
    next_digits = digits_q;
    carry       = 1'b1;
    cur_d       = 4'd0;
    nxt_d       = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cur_d = digits_q[4*k +: 4];
      nxt_d = cur_d;
      if (carry) begin
        if (up_down) begin
          if (cur_d == DMAX) begin
            nxt_d = 4'd0;
          end else begin
            nxt_d = cur_d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cur_d == 4'd0) begin
            nxt_d = DMAX;
          end else begin
            nxt_d = cur_d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_digits[4*k +: 4] = nxt_d;
    end
    roll = carry;
  end

  always_comb begin
    load_digits = load_value;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (load_value[4*k +: 4] > DMAX) begin
        load_digits[4*k +: 4] = DMAX;
      end
    end
  end

  // Reset preloads the divider from the live speed so the first period after release is full length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      div_q    <= reload_of(speed);
      speed_q  <= speed;
    end else begin
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      speed_q <= speed;
      if (load) begin
        digits_q <= load_digits;
        div_q    <= reload_of(speed);
      end else if (speed_chg) begin
        div_q <= reload_of(speed);
      end else if (enable) begin
        if (div_q == '0) begin
          digits_q <= next_digits;
          tick_q   <= 1'b1;
          wrap_q   <= roll;
          div_q    <= reload_of(speed);
        end else begin
          div_q <= div_q - DW'(1);
        end
      end
    end
  end

  assign digits = digits_q;
  assign tick   = tick_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Scoreboard bench for hex_digit_counter: value-level reference model queues expectations, a monitor compares.
module tb_hex_digit_counter;

  localparam int N  = 2;
  localparam int P1 = 4;
  localparam int P2 = 8;
  localparam int P3 = 16;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
  localparam int BASE = 10;
`else
  localparam int BASE = 16;
`endif
  localparam int MODV = BASE * BASE;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   speed = 2'b01;
  logic         up_down = 1'b1;
  logic         load = 1'b0;
  logic [4*N-1:0] load_value = '0;
  logic [4*N-1:0] digits;
  logic         tick;
  logic         wrap;

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;

  typedef struct packed {
    logic [4*N-1:0] d;
    logic           t;
    logic           w;
  } exp_t;
  exp_t q[$];

  int m_val;
  int m_rem;
  logic [1:0] m_spd;

  hex_digit_counter #(
    .NUM_DIGITS(N), .PERIOD_1(P1), .PERIOD_2(P2), .PERIOD_3(P3)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .speed(speed),
    .up_down(up_down), .load(load), .load_value(load_value),
    .digits(digits), .tick(tick), .wrap(wrap)
  );

  always #5 clock = ~clock;

  function automatic int period_of(input logic [1:0] s);
    case (s)
      2'b01:   return P1;
      2'b10:   return P2;
      2'b11:   return P3;
      default: return 1;
    endcase
  endfunction

  function automatic int vec_to_val(input logic [4*N-1:0] v);
    int r = 0;
    int dg;
    for (int k = N - 1; k >= 0; k--) begin
      dg = int'(v[4*k +: 4]);
      if (dg > BASE - 1) dg = BASE - 1;
      r = r * BASE + dg;
    end
    return r;
  endfunction

  function automatic logic [4*N-1:0] val_to_vec(input int v);
    logic [4*N-1:0] r = '0;
    int x = v;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(x % BASE);
      x = x / BASE;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the count is an integer modulo BASE^N; ticks come every period_of(speed) enabled cycles.
  always @(posedge clock or posedge reset) begin
    exp_t e;
    if (reset) begin
      m_val = 0;
      m_rem = period_of(speed);
      m_spd = speed;
    end else begin
      e.t = 1'b0;
      e.w = 1'b0;
      if (load) begin
        m_val = vec_to_val(load_value);
        m_rem = period_of(speed);
      end else if (speed != m_spd) begin
        m_rem = period_of(speed);
      end else if (enable) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          e.t = 1'b1;
          if (up_down) begin
            e.w   = (m_val == MODV - 1);
            m_val = (m_val + 1) % MODV;
          end else begin
            e.w   = (m_val == 0);
            m_val = (m_val + MODV - 1) % MODV;
          end
          m_rem = period_of(speed);
        end
      end
      m_spd = speed;
      e.d = val_to_vec(m_val);
      q.push_back(e);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      chk("digits", int'(digits), int'(e.d));
      chk("tick", int'(tick), int'(e.t));
      chk("wrap", int'(wrap), int'(e.w));
      if (tick === 1'b1) tick_seen++;
    end
  end

  task automatic cyc(input logic en, input logic [1:0] spd, input logic ud,
                     input logic ld, input logic [4*N-1:0] lv);
    enable     = en;
    speed      = spd;
    up_down    = ud;
    load       = ld;
    load_value = lv;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_digits", int'(digits), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_wrap", int'(wrap), 0);

    reset     = 1'b0;
    tick_seen = 0;
    repeat (40) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    #1;
    chk("ticks_in_40", tick_seen, 10);

    cyc(1'b1, 2'b00, 1'b1, 1'b1, 8'hFE);
    repeat (4) cyc(1'b1, 2'b00, 1'b1, 1'b0, '0);

    cyc(1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
    repeat (3) cyc(1'b1, 2'b00, 1'b0, 1'b0, '0);

    cyc(1'b0, 2'b00, 1'b1, 1'b1, 8'h3C);
    #1;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    chk("load_3c", int'(digits), 'h39);
`else
    chk("load_3c", int'(digits), 'h3C);
`endif

    repeat (6) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    repeat (10) cyc(1'b0, 2'b01, 1'b1, 1'b0, '0);
    repeat (8) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);

    repeat (2) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    repeat (20) cyc(1'b1, 2'b11, 1'b1, 1'b0, '0);

    cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    for (int i = 0; i < 20 && m_rem != 1; i++) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 8'h5A);
    repeat (6) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);

    cyc(1'b1, 2'b01, 1'b1, 1'b1, 8'h37);
    repeat (2) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    #2;
    chk("pre_reset_digits", int'(digits), 'h37);
    reset = 1'b1;
    #1;
    chk("async_reset_digits", int'(digits), 0);
    chk("async_reset_tick", int'(tick), 0);
    @(negedge clock);
    reset     = 1'b0;
    tick_seen = 0;
    repeat (4) cyc(1'b1, 2'b01, 1'b1, 1'b0, '0);
    #1;
    chk("restart_full_period", tick_seen, 1);

    begin
      logic [1:0] rs;
      rs = 2'b00;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) rs = 2'($urandom_range(0, 3));
        cyc(($urandom_range(0, 9) != 0), rs, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 29) == 0), 8'($urandom));
      end
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_digit_counter.md
Name: hex_digit_counter

Overview:
- Sequential digit source that directly feeds the team's 7-segment hex decoder stage; each 4-bit digit output drives one decoder instance.
- Multi-digit up/down counter advanced by an internal rate divider with selectable speed, synchronous parallel load and pause.
- Used for lab display demos (counting clocks, timers) on 50 MHz boards.

Parameters:
- NUM_DIGITS, 2, number of 4-bit digits (1..8); digit 0 is least significant.
- PERIOD_1, 50000000, clock cycles per tick at speed 01 (1 Hz at 50 MHz).
- PERIOD_2, 25000000, clock cycles per tick at speed 10.
- PERIOD_3, 12500000, clock cycles per tick at speed 11.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = divider and counter run; 0 = both hold.
- speed  in  2  tick rate select: 00 every cycle, 01/10/11 = PERIOD_1/2/3.
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load strobe.
- load_value  in  4*NUM_DIGITS  value written on load.
- digits  out  4*NUM_DIGITS  current count; digit k at bits [4k+3:4k].
- tick  out  1  one-cycle pulse, high in the cycle the count advances.
- wrap  out  1  one-cycle pulse, high in the cycle the count rolls over.

Behaviour:
- Reset (async, any time incl. mid-count): digits = 0, tick = 0, wrap = 0, divider loaded with selected period - 1. Takes effect immediately, not at the next edge.
- Divider: down-counter, width = clog2(max period). When enable = 1 it decrements each cycle. On reaching 0 it asserts internal tick for that cycle and reloads period - 1.
- Speed 00: tick every enabled cycle.
- Speed change: detected by comparing against a registered copy of speed. The divider reloads with the new period - 1 on the cycle after the change, with no tick in that cycle.
- enable = 0: divider and digits hold; tick and wrap are 0.
- Priority, highest first: reset > load > tick.
  - load = 1: digits <= load_value and divider reloads at the next edge; tick and wrap are 0 that cycle, regardless of enable.
- Count step on tick:
  - up_down = 1: digit 0 increments; carry ripples to digit k when all lower digits are at max.
  - up_down = 0: decrement with the same borrow rule.
  - Hex mode: digit max = 4'hF. Count is modulo 16^NUM_DIGITS.
- Wrap:
  - Up from all-max gives all-zero; down from all-zero gives all-max.
  - wrap pulses in the same cycle as tick for that step.
- Output timing: tick and wrap are registered and asserted in the cycle digits first shows the new value, i.e. 1 cycle after the divider reaches 0.
- up_down is sampled only on tick cycles; changing it between ticks has no other effect.
- Outputs are registered only: no combinational path from inputs to digits.

Optional Feature:
- Macro: HEX_DIGIT_COUNTER_BCD_EN.
- Defined:
  - Each digit counts 0..9 (BCD). Digit max = 9; carry/borrow at 9/0. Count is modulo 10^NUM_DIGITS.
  - Up from all-9 wraps to all-0 with wrap pulse; down from all-0 wraps to all-9.
  - On load, any load_value digit > 9 is stored as 9.
- Undefined: pure hex behaviour as above; load_value is stored unmodified.

Test Plan:
- Bench parameters: NUM_DIGITS=2, PERIOD_1=4, PERIOD_2=8, PERIOD_3=16.
- Reset then enable=1, speed=01, up_down=1 for 40 cycles -> digits 00,01,02,... advancing every 4 cycles; one tick per advance; wrap=0.
- load=1 with load_value=8'hFE, then count up at speed 00 -> digits FE, FF, 00; wrap high exactly in the cycle 00 appears.
- From 8'h00 with up_down=0, speed 00 -> FF with wrap pulse, then FE. With BCD_EN: 00 -> 99 -> 98; load 8'h3C stores 39.
- Pause and speed change:
  - Drop enable for 10 cycles mid-period -> digits and divider frozen; on resume the remaining period completes.
  - Switch speed 01->11 mid-period -> first tick 1+16 cycles after the change.
- Load vs tick: assert load in the same cycle as a tick with load_value=8'h5A -> digits=5A, tick=0, next advance a full period later.
- Async reset mid-period with digits=8'h37 -> digits=00 and tick=0 without waiting for a clock edge; counting restarts with a full period after release.
